// File: rtl/cntry_vehicle_detect_if.sv
// Signal bundle between the country-road loop conditioner and its environment:
// raw sensor and light code in, car-waiting request and queue status out.
interface cntry_vehicle_detect_if #(
    parameter int CNT_W = 4
);
    logic             loop_raw;
    logic [1:0]       cntry;
    logic             X;
    logic [CNT_W-1:0] car_count;
    logic             wait_full;
    logic             sat;

    modport master (
        output loop_raw, cntry,
        input  X, car_count, wait_full, sat
    );

    modport slave (
        input  loop_raw, cntry,
        output X, car_count, wait_full, sat
    );
endinterface

// File: rtl/cntry_vehicle_detect.sv
// Country-road vehicle detector: synchronizes and debounces the loop sensor,
// keeps a saturating queue count drained during GREEN, and raises X for the controller.
module cntry_vehicle_detect #(
    parameter int DEBOUNCE      = 4,
    parameter int CNT_W         = 4,
    parameter int THRESH        = 2,
    parameter int MAX_WAIT      = 20,
    parameter int DEPART_CYCLES = 3
) (
    input  logic                  clock,
    input  logic                  clear,
    cntry_vehicle_detect_if.slave bus
);
    localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int DEP_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
    localparam int WT_W  = $clog2(MAX_WAIT + 1);
    localparam logic [1:0]       GREEN   = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } db_state_e;

    logic             s1_q, s2_q;
    db_state_e        state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [DEP_W-1:0] dep_cnt_q, dep_cnt_d;
    logic [WT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0] car_count_q, car_count_d;
    logic             sat_q, sat_d;
    logic             arrival_s, depart_s, green_s, level_s, nonempty_s, x_s;

    assign green_s    = (bus.cntry == GREEN);
    assign level_s    = (state_q == PRESENT);
    assign nonempty_s = (car_count_q != {CNT_W{1'b0}});

    // Debounce: accept a new level after DEBOUNCE consecutive disagreeing samples.
    always_comb begin
        state_d   = state_q;
        db_cnt_d  = '0;
        arrival_s = 1'b0;
        if (s2_q != level_s) begin
            if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
                db_cnt_d = '0;
                case (state_q)
                    IDLE: begin
                        state_d   = PRESENT;
                        arrival_s = 1'b1;
                    end
                    PRESENT: state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_d = '0;
        end
    end

    // Departure pacing, queue count with saturation, and wait timer.
    always_comb begin
        dep_cnt_d   = '0;
        depart_s    = 1'b0;
        car_count_d = car_count_q;
        sat_d       = sat_q;
        wait_d      = '0;
        if (green_s && nonempty_s) begin
            if (dep_cnt_q == DEP_W'(DEPART_CYCLES - 1)) begin
                dep_cnt_d = '0;
                depart_s  = 1'b1;
            end else begin
                dep_cnt_d = dep_cnt_q + DEP_W'(1);
            end
        end else begin
            dep_cnt_d = '0;
        end

        // An arrival coinciding with a departure cancels out and cannot saturate.
        if (arrival_s && !depart_s) begin
            if (car_count_q == CNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                car_count_d = car_count_q + CNT_W'(1);
            end
        end else if (depart_s && !arrival_s && nonempty_s) begin
            car_count_d = car_count_q - CNT_W'(1);
        end else begin
            car_count_d = car_count_q;
        end

        if (nonempty_s && !green_s) begin
            wait_d = (wait_q == WT_W'(MAX_WAIT)) ? wait_q : wait_q + WT_W'(1);
        end else begin
            wait_d = '0;
        end
    end

    // Request to the controller; during GREEN it holds until the queue is empty.
    always_comb begin
        x_s = 1'b0;
        if (green_s) begin
            x_s = nonempty_s;
        end else begin
            x_s = (car_count_q >= CNT_W'(THRESH)) ||
                  ((wait_q == WT_W'(MAX_WAIT)) && nonempty_s);
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            dep_cnt_q   <= '0;
            wait_q      <= '0;
            car_count_q <= '0;
            sat_q       <= 1'b0;
        end else begin
            s1_q        <= bus.loop_raw;
            s2_q        <= s1_q;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            dep_cnt_q   <= dep_cnt_d;
            wait_q      <= wait_d;
            car_count_q <= car_count_d;
            sat_q       <= sat_d;
        end
    end

    assign bus.X         = x_s;
    assign bus.car_count = car_count_q;
    assign bus.wait_full = (wait_q == WT_W'(MAX_WAIT));
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_cntry_vehicle_detect.sv
// Randomized and directed bench for cntry_vehicle_detect against a cycle-level
// behavioural model of the detector's rules.
module tb_cntry_vehicle_detect;
    localparam int DEBOUNCE      = 4;
    localparam int CNT_W         = 4;
    localparam int THRESH        = 2;
    localparam int MAX_WAIT      = 20;
    localparam int DEPART_CYCLES = 3;
    localparam int CNT_MAX       = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   errors = 0;
    int   checks = 0;

    cntry_vehicle_detect_if #(.CNT_W(CNT_W)) bus ();

    cntry_vehicle_detect #(
        .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W), .THRESH(THRESH),
        .MAX_WAIT(MAX_WAIT), .DEPART_CYCLES(DEPART_CYCLES)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Reference model: sample history, debounced level with run length, and counters as plain ints.
    int m_hist[2];
    int m_level, m_run, m_green_cycles, m_count, m_wait, m_sat;

    task automatic model_reset();
        m_hist[0] = 0; m_hist[1] = 0;
        m_level = 0; m_run = 0; m_green_cycles = 0;
        m_count = 0; m_wait = 0; m_sat = 0;
    endtask

    task automatic model_step(input int raw, input int c);
        int seen, arrive, depart, draining, next_wait;
        seen   = m_hist[1];
        arrive = 0;
        depart = 0;
        draining = (c == 2) && (m_count > 0);
        if (seen != m_level) begin
            m_run = m_run + 1;
            if (m_run >= DEBOUNCE) begin
                arrive  = (seen == 1);
                m_level = seen;
                m_run   = 0;
            end
        end else begin
            m_run = 0;
        end
        if (draining) begin
            m_green_cycles = m_green_cycles + 1;
            if (m_green_cycles % DEPART_CYCLES == 0) depart = 1;
        end else begin
            m_green_cycles = 0;
        end
        next_wait = (m_count > 0 && c != 2) ? ((m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1) : 0;
        if (arrive && !depart) begin
            if (m_count == CNT_MAX) m_sat = 1;
            else m_count = m_count + 1;
        end else if (depart && !arrive) begin
            m_count = (m_count > 0) ? m_count - 1 : 0;
        end
        m_wait = next_wait;
        m_hist[1] = m_hist[0];
        m_hist[0] = raw;
    endtask

    function automatic int exp_x();
        if (bus.cntry == 2'd2) return (m_count != 0) ? 1 : 0;
        return ((m_count >= THRESH) || (m_wait == MAX_WAIT && m_count != 0)) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clock);
        if (clear) model_reset();
        else model_step(int'(bus.loop_raw), int'(bus.cntry));
        #1;
    endtask

    task automatic arrive_pulse();
        bus.loop_raw = 1'b1;
        repeat (6) tick();
        bus.loop_raw = 1'b0;
        repeat (6) tick();
    endtask

    task automatic do_clear();
        #2 clear = 1'b1;
        model_reset();
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        bus.loop_raw = 1'b0;
        bus.cntry    = 2'd0;
        clear        = 1'b1;
        model_reset();
        repeat (2) tick();
        checks++; if ({bus.X, bus.car_count, bus.wait_full, bus.sat} !== '0) begin errors++; $display("FAIL reset_state got=%b want=0", {bus.X, bus.car_count, bus.wait_full, bus.sat}); end
        clear = 1'b0;
        repeat (5) arrive_pulse();
        checks++; if (bus.car_count !== 4'd5) begin errors++; $display("FAIL pre_clear_count got=%0d want=5", bus.car_count); end
        #2 clear = 1'b1;
        #1;
        model_reset();
        checks++; if ({bus.X, bus.car_count, bus.wait_full, bus.sat} !== '0) begin errors++; $display("FAIL async_clear got=%b want=0", {bus.X, bus.car_count, bus.wait_full, bus.sat}); end
        tick();
        clear = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++; if (bus.X !== 1'b0) begin errors++; $display("FAIL idle_x cycle=%0d got=%b want=0", i, bus.X); end
        end
    endtask

    task automatic test_debounce();
        do_clear();
        bus.loop_raw = 1'b1;
        repeat (3) tick();
        bus.loop_raw = 1'b0;
        repeat (10) tick();
        checks++; if (bus.car_count !== 4'd0) begin errors++; $display("FAIL glitch_count got=%0d want=0", bus.car_count); end
        bus.loop_raw = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            tick();
            if (e == 4) begin
                checks++; if (bus.car_count !== 4'd0) begin errors++; $display("FAIL latency_edge4 got=%0d want=0", bus.car_count); end
            end else if (e == 5) begin
                checks++; if (bus.car_count !== 4'd1) begin errors++; $display("FAIL latency_edge5 got=%0d want=1", bus.car_count); end
            end
        end
        repeat (2) tick();
        bus.loop_raw = 1'b0;
        repeat (2) tick();
        bus.loop_raw = 1'b1;
        repeat (3) tick();
        bus.loop_raw = 1'b0;
        repeat (10) tick();
        checks++; if (bus.car_count !== 4'd1) begin errors++; $display("FAIL dropout_count got=%0d want=1", bus.car_count); end
    endtask

    task automatic test_threshold();
        do_clear();
        bus.cntry = 2'd0;
        bus.loop_raw = 1'b1;
        for (int i = 0; i < 20 && m_count < 1; i++) tick();
        checks++; if (bus.X !== 1'b0 || bus.car_count !== 4'd1) begin errors++; $display("FAIL first_arrival x=%b cnt=%0d want x=0 cnt=1", bus.X, bus.car_count); end
        bus.loop_raw = 1'b0;
        repeat (6) tick();
        bus.loop_raw = 1'b1;
        for (int i = 0; i < 20 && m_count < 2; i++) begin
            tick();
            checks++; if (bus.X !== exp_x()) begin errors++; $display("FAIL thresh_x got=%b want=%0d", bus.X, exp_x()); end
        end
        checks++; if (bus.X !== 1'b1 || bus.car_count !== 4'd2) begin errors++; $display("FAIL thresh_two x=%b cnt=%0d want x=1 cnt=2", bus.X, bus.car_count); end
        bus.loop_raw = 1'b0;

        do_clear();
        bus.loop_raw = 1'b1;
        for (int i = 0; i < 20 && m_count < 1; i++) tick();
        bus.loop_raw = 1'b0;
        for (int k = 1; k <= MAX_WAIT; k++) begin
            tick();
            if (k < MAX_WAIT) begin
                checks++; if (bus.X !== 1'b0 || bus.wait_full !== 1'b0) begin errors++; $display("FAIL wait_early k=%0d x=%b wf=%b want 0", k, bus.X, bus.wait_full); end
            end else begin
                checks++; if (bus.X !== 1'b1 || bus.wait_full !== 1'b1) begin errors++; $display("FAIL wait_full k=%0d x=%b wf=%b want 1", k, bus.X, bus.wait_full); end
            end
        end
    endtask

    task automatic test_drain();
        int exp_cnt;
        do_clear();
        bus.cntry = 2'd0;
        repeat (3) arrive_pulse();
        checks++; if (bus.car_count !== 4'd3) begin errors++; $display("FAIL drain_start got=%0d want=3", bus.car_count); end
        bus.cntry = 2'd2;
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_cnt = 3 - k / DEPART_CYCLES;
            checks++; if (bus.car_count !== 4'(exp_cnt) || bus.X !== (exp_cnt != 0) || bus.wait_full !== 1'b0) begin
                errors++; $display("FAIL drain k=%0d cnt=%0d x=%b wf=%b want cnt=%0d", k, bus.car_count, bus.X, bus.wait_full, exp_cnt);
            end
        end
        bus.cntry = 2'd0;
    endtask

    task automatic test_back_to_back();
        do_clear();
        bus.cntry = 2'd0;
        repeat (2) arrive_pulse();
        bus.cntry    = 2'd2;
        bus.loop_raw = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 3 || k == 6) begin
                checks++; if (bus.car_count !== 4'd1 || bus.sat !== 1'b0) begin errors++; $display("FAIL simultaneous k=%0d cnt=%0d sat=%b want cnt=1 sat=0", k, bus.car_count, bus.sat); end
            end
        end
        checks++; if (bus.car_count !== 4'd0 || bus.X !== 1'b0) begin errors++; $display("FAIL sim_drain cnt=%0d x=%b want 0", bus.car_count, bus.X); end
        bus.loop_raw = 1'b0;
        bus.cntry    = 2'd0;
        repeat (6) tick();
    endtask

    task automatic test_saturation();
        do_clear();
        bus.cntry = 2'd0;
        for (int i = 1; i <= CNT_MAX + 1; i++) begin
            arrive_pulse();
            if (i == CNT_MAX) begin
                checks++; if (bus.car_count !== 4'd15 || bus.sat !== 1'b0) begin errors++; $display("FAIL sat_15 cnt=%0d sat=%b want 15/0", bus.car_count, bus.sat); end
            end
        end
        checks++; if (bus.car_count !== 4'd15 || bus.sat !== 1'b1) begin errors++; $display("FAIL sat_16 cnt=%0d sat=%b want 15/1", bus.car_count, bus.sat); end
        bus.cntry = 2'd2;
        repeat (CNT_MAX * DEPART_CYCLES + 2) tick();
        checks++; if (bus.car_count !== 4'd0 || bus.sat !== 1'b1 || bus.X !== 1'b0) begin errors++; $display("FAIL sat_drain cnt=%0d sat=%b x=%b want 0/1/0", bus.car_count, bus.sat, bus.X); end
        bus.cntry = 2'd0;
        #2 clear = 1'b1;
        #1;
        model_reset();
        checks++; if (bus.sat !== 1'b0) begin errors++; $display("FAIL sat_clear got=%b want=0", bus.sat); end
        tick();
        clear = 1'b0;
    endtask

    task automatic test_random();
        int raw_hold, c_hold;
        do_clear();
        raw_hold = 0;
        c_hold   = 0;
        for (int n = 0; n < 3000; n++) begin
            if (raw_hold == 0) begin
                bus.loop_raw = ~bus.loop_raw;
                raw_hold = int'($urandom_range(1, 9));
            end
            if (c_hold == 0) begin
                bus.cntry = 2'($urandom_range(0, 3));
                c_hold = int'($urandom_range(1, 40));
            end
            raw_hold--;
            c_hold--;
            tick();
            checks++; if (bus.car_count !== 4'(m_count) || bus.X !== exp_x() || bus.wait_full !== (m_wait == MAX_WAIT) || bus.sat !== 1'(m_sat)) begin
                errors++; $display("FAIL random n=%0d cnt=%0d x=%b wf=%b sat=%b want cnt=%0d x=%0d wait=%0d sat=%0d",
                                   n, bus.car_count, bus.X, bus.wait_full, bus.sat, m_count, exp_x(), m_wait, m_sat);
            end
        end
        bus.loop_raw = 1'b0;
        bus.cntry    = 2'd0;
    endtask

    initial begin
        bus.loop_raw = 1'b0;
        bus.cntry    = 2'd0;
        model_reset();
        test_reset();
        test_debounce();
        test_threshold();
        test_drain();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
